// File: rtl/id_pkg.sv
// Shared definitions for the instruction-decode stage: default widths,
// the ID/EX bundle layout and the all-zero bubble value.
package id_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int IMM_W      = 7;
  localparam int FUNCT_W    = 3;

  // ID/EX bundle at the default widths. EX-side logic built at these widths
  // can use this type directly. The decode stage keeps its own bundle,
  // sized from its parameters, so non-default builds stay consistent.
  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [FUNCT_W-1:0]    funct;
    logic [DATA_W-1:0]     pc4;
  } id_ex_t;

  // An empty pipeline slot: no valid instruction and every field zero.
  localparam id_ex_t ID_BUBBLE = '0;

endpackage

// File: rtl/id_regfile.sv
// Register file for the decode stage: two combinational read ports, one
// write port, register 0 hardwired to zero, and write-through bypass so a
// value being written back this cycle is visible to readers this cycle.
module id_regfile
  import id_pkg::*;
#(
  parameter int DATA_W     = id_pkg::DATA_W,
  parameter int REG_ADDR_W = id_pkg::REG_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] ra1_i,
  input  logic [REG_ADDR_W-1:0] ra2_i,
  output logic [DATA_W-1:0]     rd1_o,
  output logic [DATA_W-1:0]     rd2_o,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0]     wd_i
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;

  // Writes aimed at register 0 are discarded.
  assign wr_en = we_i && (wa_i != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] val_q;

        // Each register captures write-back data when addressed.
        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            val_q <= '0;
          end else if (wr_en && (wa_i == REG_ADDR_W'(gi))) begin
            val_q <= wd_i;
          end
        end

        assign regs[gi] = val_q;
      end
    end
  endgenerate

  // Read ports forward in-flight write-back data ahead of the stored value.
  always_comb begin
    rd1_o = regs[ra1_i];
    rd2_o = regs[ra2_i];
    if (wr_en && (wa_i == ra1_i)) rd1_o = wd_i;
    if (wr_en && (wa_i == ra2_i)) rd2_o = wd_i;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage for the 16-bit pipelined processor. Reads the
// register file, sign-extends the immediate, detects load-use hazards
// (stalling IF) and registers the decode results into the ID/EX register.
// Build option: define ID_STALL_CNT_EN to add a saturating stall counter
// output (stall_cnt).
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_W     = id_pkg::DATA_W,
  parameter int REG_ADDR_W = id_pkg::REG_ADDR_W,
  parameter int IMM_W      = id_pkg::IMM_W,
  parameter int FUNCT_W    = id_pkg::FUNCT_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic [IMM_W-1:0]      imm,
  input  logic [DATA_W-1:0]     pc4,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  flush,
  output logic                  stall,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     rd1_q,
  output logic [DATA_W-1:0]     rd2_q,
  output logic [DATA_W-1:0]     imm_q,
  output logic [REG_ADDR_W-1:0] rs_q,
  output logic [REG_ADDR_W-1:0] rt_q,
  output logic [REG_ADDR_W-1:0] rd_q,
  output logic [FUNCT_W-1:0]    funct_q,
  output logic [DATA_W-1:0]     pc4_q
`ifdef ID_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  // ID/EX bundle sized from this instance's parameters.
  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [FUNCT_W-1:0]    funct;
    logic [DATA_W-1:0]     pc4;
  } idex_t;

  localparam idex_t BUBBLE = '0;

  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;
  logic [DATA_W-1:0] imm_ext;
  logic              hazard;
  idex_t             idex_q;
  idex_t             idex_d;

  id_regfile #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .ra1_i   (rs),
    .ra2_i   (rt),
    .rd1_o   (rf_rd1),
    .rd2_o   (rf_rd2),
    .we_i    (wb_we),
    .wa_i    (wb_addr),
    .wd_i    (wb_data)
  );

  // Sign extension bit by bit; also covers IMM_W == DATA_W cleanly.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_sext
      if (gi < IMM_W) begin : g_copy
        assign imm_ext[gi] = imm[gi];
      end else begin : g_sign
        assign imm_ext[gi] = imm[IMM_W-1];
      end
    end
  endgenerate

  // Load-use hazard: the load in EX writes a register this instruction reads.
  // A taken branch squashes the instruction anyway, so it never stalls, and
  // nothing stalls while the pipeline is held in reset.
  assign hazard = in_valid && ex_mem_read && (ex_rt != '0) &&
                  ((ex_rt == rs) || (ex_rt == rt));
  assign stall  = hazard && !flush && reset_n;

  // Next ID/EX contents: bubble on flush or stall, otherwise this decode.
  always_comb begin
    idex_d = BUBBLE;
    if (!flush && !stall) begin
      idex_d.valid = in_valid;
      idex_d.rd1   = rf_rd1;
      idex_d.rd2   = rf_rd2;
      idex_d.imm   = imm_ext;
      idex_d.rs    = rs;
      idex_d.rt    = rt;
      idex_d.rd    = rd;
      idex_d.funct = funct;
      idex_d.pc4   = pc4;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idex_q <= BUBBLE;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign out_valid = idex_q.valid;
  assign rd1_q     = idex_q.rd1;
  assign rd2_q     = idex_q.rd2;
  assign imm_q     = idex_q.imm;
  assign rs_q      = idex_q.rs;
  assign rt_q      = idex_q.rt;
  assign rd_q      = idex_q.rd;
  assign funct_q   = idex_q.funct;
  assign pc4_q     = idex_q.pc4;

`ifdef ID_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Counts stalled cycles, holding at the maximum instead of wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed testbench for id_stage_pipe: register file write/bypass, r0,
// immediate extension, load-use stall, flush priority and async reset.
module tb_id_stage_pipe;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [2:0]  rs, rt, rd;
  logic [2:0]  funct;
  logic [6:0]  imm;
  logic [15:0] pc4;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ex_mem_read;
  logic [2:0]  ex_rt;
  logic        flush;
  logic        stall;
  logic        out_valid;
  logic [15:0] rd1_q, rd2_q, imm_q, pc4_q;
  logic [2:0]  rs_q, rt_q, rd_q, funct_q;
`ifdef ID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_cmp;
  int n_bad;

  id_stage_pipe dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .funct       (funct),
    .imm         (imm),
    .pc4         (pc4),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .flush       (flush),
    .stall       (stall),
    .out_valid   (out_valid),
    .rd1_q       (rd1_q),
    .rd2_q       (rd2_q),
    .imm_q       (imm_q),
    .rs_q        (rs_q),
    .rt_q        (rt_q),
    .rd_q        (rd_q),
    .funct_q     (funct_q),
    .pc4_q       (pc4_q)
`ifdef ID_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; rs = 0; rt = 0; rd = 0; funct = 0; imm = 0; pc4 = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0; ex_mem_read = 0; ex_rt = 0; flush = 0;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'h0);
    check({tag, ".rd1"},   32'(rd1_q),     32'h0);
    check({tag, ".imm"},   32'(imm_q),     32'h0);
    check({tag, ".pc4"},   32'(pc4_q),     32'h0);
    check({tag, ".rs"},    32'(rs_q),      32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    reset_n = 0;
    // Hazard pattern present during reset must not raise stall.
    in_valid = 1; ex_mem_read = 1; ex_rt = 3'd2; rs = 3'd2;
    #3;
    check("rst_stall", 32'(stall), 32'h0);
    check_bubble("rst");
    #9;
    idle();
    reset_n = 1;

    // Write r3 = 1234, then read it back.
    wb_we = 1; wb_addr = 3'd3; wb_data = 16'h1234;
    tick();
    idle();
    in_valid = 1; rs = 3'd3; rt = 3'd0; rd = 3'd6; funct = 3'd5; pc4 = 16'h0104;
    tick();
    check("wr_r3.valid", 32'(out_valid), 32'h1);
    check("wr_r3.rd1",   32'(rd1_q),     32'h1234);
    check("wr_r3.rd2",   32'(rd2_q),     32'h0);
    check("wr_r3.rs",    32'(rs_q),      32'h3);
    check("wr_r3.rd",    32'(rd_q),      32'h6);
    check("wr_r3.funct", 32'(funct_q),   32'h5);
    check("wr_r3.pc4",   32'(pc4_q),     32'h0104);

    // Same-cycle write-through on rs; rt reads the stored r3.
    idle();
    in_valid = 1; rs = 3'd5; rt = 3'd3;
    wb_we = 1; wb_addr = 3'd5; wb_data = 16'hBEEF;
    tick();
    check("bypass.rd1", 32'(rd1_q), 32'hBEEF);
    check("bypass.rd2", 32'(rd2_q), 32'h1234);
    check("bypass.rt",  32'(rt_q),  32'h3);

    // Writes to r0 are ignored, including the bypass path.
    idle();
    in_valid = 1; rs = 3'd0; rt = 3'd5;
    wb_we = 1; wb_addr = 3'd0; wb_data = 16'hFFFF;
    tick();
    check("r0_same.rd1", 32'(rd1_q), 32'h0);
    check("r5_kept.rd2", 32'(rd2_q), 32'hBEEF);
    idle();
    in_valid = 1; rs = 3'd0;
    tick();
    check("r0_next.rd1", 32'(rd1_q), 32'h0);

    // Immediate sign extension, negative then positive.
    idle();
    in_valid = 1; imm = 7'b1000001;
    tick();
    check("imm_neg", 32'(imm_q), 32'hFFC1);
    imm = 7'b0111111;
    tick();
    check("imm_pos", 32'(imm_q), 32'h003F);

    // Hazard detection on rt and the ex_rt==0 exemption (combinational only).
    idle();
    in_valid = 1; rs = 3'd1; rt = 3'd4; ex_mem_read = 1; ex_rt = 3'd4;
    #1;
    check("haz_rt.stall", 32'(stall), 32'h1);
    rs = 3'd0; rt = 3'd0; ex_rt = 3'd0;
    #1;
    check("haz_r0.stall", 32'(stall), 32'h0);
    in_valid = 0; rs = 3'd4; ex_rt = 3'd4;
    #1;
    check("haz_inv.stall", 32'(stall), 32'h0);

    // Load-use on rs with a concurrent write-back of r2.
    idle();
    @(negedge clock);
    in_valid = 1; rs = 3'd2; rt = 3'd3; imm = 7'h11; pc4 = 16'h0200;
    ex_mem_read = 1; ex_rt = 3'd2;
    wb_we = 1; wb_addr = 3'd2; wb_data = 16'h2222;
    #1;
    check("lu.stall", 32'(stall), 32'h1);
    tick();
    check_bubble("lu_bub");
    ex_mem_read = 0; ex_rt = 3'd0; wb_we = 0;
    #1;
    check("lu_rel.stall", 32'(stall), 32'h0);
    tick();
    check("lu_iss.valid", 32'(out_valid), 32'h1);
    check("lu_iss.rd1",   32'(rd1_q),     32'h2222);
    check("lu_iss.rd2",   32'(rd2_q),     32'h1234);
    check("lu_iss.pc4",   32'(pc4_q),     32'h0200);
`ifdef ID_STALL_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'h1);
`endif

    // Flush together with a hazard: flush wins.
    ex_mem_read = 1; ex_rt = 3'd2; flush = 1;
    #1;
    check("flush.stall", 32'(stall), 32'h0);
    tick();
    check_bubble("flush_bub");

    // Fields load even for an invalid slot.
    idle();
    in_valid = 0; rs = 3'd3; pc4 = 16'h0ABC;
    tick();
    check("inv.valid", 32'(out_valid), 32'h0);
    check("inv.rd1",   32'(rd1_q),     32'h1234);
    check("inv.pc4",   32'(pc4_q),     32'h0ABC);

    // Asynchronous reset mid-stream, then register contents are gone.
    in_valid = 1;
    tick();
    check("pre_rst.valid", 32'(out_valid), 32'h1);
    #2;
    reset_n = 0;
    #1;
    check_bubble("async_rst");
    #3;
    idle();
    reset_n = 1;
    in_valid = 1; rs = 3'd3; rt = 3'd5;
    tick();
    check("post_rst.rd1", 32'(rd1_q), 32'h0);
    check("post_rst.rd2", 32'(rd2_q), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
